// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//   x4 quadrature decoder for incremental-encoder A/B channels. The asynchronous
//   A/B inputs are synchronised, then each Gray-code phase transition is decoded
//   into an up or down step that updates a WIDTH-bit modulo position count.
//
//   Parameters
//     WIDTH        position counter width in bits
//     SYNC_STAGES  synchroniser flops per input channel (2..4)
//
//   Ports
//     clk     system clock, all state on rising edge
//     reset   asynchronous, active-high reset
//     enable  1 = steps update count; 0 = count holds, phase still tracked
//     clear   synchronous; zeroes count and clears err
//     a, b    encoder channels, asynchronous
//     idx     encoder index (Z), asynchronous (QUAD_INDEX_EN builds only)
//     count   position count
//     dir     direction of last valid step, 1 = up
//     step    one-cycle pulse per valid step (also while enable = 0)
//     err     sticky illegal-transition flag
//
//   Build option
//     QUAD_INDEX_EN  when defined, adds the idx port; a synchronised idx rising
//                    edge in RUN with enable = 1 defines position 0.
// -----------------------------------------------------------------------------
module quad_decoder #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             a,
    input  logic             b,
`ifdef QUAD_INDEX_EN
    input  logic             idx,
`endif
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // INIT lasts SYNC_STAGES+1 cycles: counter values 0..SYNC_STAGES
    localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] a_sync_r;
    logic [SYNC_STAGES-1:0] b_sync_r;
    logic [1:0]             ab_s;
    logic [1:0]             prev_ab_r;
    state_t                 state_r;
    state_t                 state_s;
    logic [2:0]             init_cnt_r;
    logic                   run_s;
    logic                   load_prev_s;
    logic                   step_s;
    logic                   up_s;
    logic                   illegal_s;
    logic                   idx_rise_s;
    logic [1:0]             pos_diff_s;
    logic [WIDTH-1:0]       count_r;
    logic                   dir_r;
    logic                   step_r;
    logic                   err_r;

    // Map Gray phase {a,b} onto a 2-bit position so the step direction is a
    // modulo-4 difference: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] phase_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // Input synchronisers for A and B
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync_r <= {SYNC_STAGES{1'b0}};
            b_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], a};
            b_sync_r <= {b_sync_r[SYNC_STAGES-2:0], b};
        end
    end

    assign ab_s = {a_sync_r[SYNC_STAGES-1], b_sync_r[SYNC_STAGES-1]};

    // FSM state register and INIT fill counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= 3'd0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + 3'd1;
            end else begin
                init_cnt_r <= 3'd0;
            end
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_INIT;
        endcase
    end

    // FSM outputs: decode enable and previous-phase load
    always_comb begin
        run_s       = 1'b0;
        load_prev_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                run_s       = 1'b0;
                load_prev_s = (init_cnt_r == INIT_LAST);
            end
            ST_RUN: begin
                run_s       = 1'b1;
                load_prev_s = 1'b1;
            end
            default: begin
                run_s       = 1'b0;
                load_prev_s = 1'b0;
            end
        endcase
    end

    // Previous synchronised phase, tracked regardless of enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ab_r <= 2'b00;
        end else if (load_prev_s) begin
            prev_ab_r <= ab_s;
        end else begin
            prev_ab_r <= prev_ab_r;
        end
    end

    assign pos_diff_s = phase_pos(ab_s) - phase_pos(prev_ab_r);

    // Transition decode: +1 = up, -1 = down, 2 = both bits changed
    always_comb begin
        step_s    = 1'b0;
        up_s      = 1'b0;
        illegal_s = 1'b0;
        if (run_s) begin
            case (pos_diff_s)
                2'd1: begin
                    step_s = 1'b1;
                    up_s   = 1'b1;
                end
                2'd3: begin
                    step_s = 1'b1;
                    up_s   = 1'b0;
                end
                2'd2:    illegal_s = 1'b1;
                default: step_s    = 1'b0;
            endcase
        end else begin
            step_s = 1'b0;
        end
    end

`ifdef QUAD_INDEX_EN
    logic [SYNC_STAGES-1:0] idx_sync_r;
    logic                   idx_prev_r;
    logic                   idx_s;

    // Index synchroniser and edge-detect history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_sync_r <= {SYNC_STAGES{1'b0}};
            idx_prev_r <= 1'b0;
        end else begin
            idx_sync_r <= {idx_sync_r[SYNC_STAGES-2:0], idx};
            idx_prev_r <= idx_s;
        end
    end

    assign idx_s      = idx_sync_r[SYNC_STAGES-1];
    assign idx_rise_s = idx_s & ~idx_prev_r & run_s;
`else
    assign idx_rise_s = 1'b0;
`endif

    // Position count: clear beats index, index defines 0 before the step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (idx_rise_s && enable) begin
            if (step_s) begin
                count_r <= up_s ? WIDTH'(1'b1) : {WIDTH{1'b1}};
            end else begin
                count_r <= {WIDTH{1'b0}};
            end
        end else if (step_s && enable) begin
            count_r <= up_s ? (count_r + WIDTH'(1'b1)) : (count_r - WIDTH'(1'b1));
        end else begin
            count_r <= count_r;
        end
    end

    // Step pulse, direction and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_r <= 1'b0;
            dir_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            step_r <= step_s;
            if (step_s) begin
                dir_r <= up_s;
            end else begin
                dir_r <= dir_r;
            end
            if (clear) begin
                err_r <= 1'b0;
            end else if (illegal_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign count = count_r;
    assign dir   = dir_r;
    assign step  = step_r;
    assign err   = err_r;

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder for incremental-encoder A/B channels; the receiving end of an encoder interface.
- Synchronises the asynchronous A/B inputs and decodes Gray-code phase transitions into x4 up/down steps.
- Keeps a WIDTH-bit signed-agnostic position count, plus direction, step-pulse and error flags.
- Feeds position into control and status logic, and can drive a downstream up/down counter via step/dir.

Parameters:
- WIDTH, 16, position counter width in bits.
- SYNC_STAGES, 2, synchroniser flops per input channel; legal values 2..4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = steps update count; 0 = count holds, phase tracking continues.
- clear  input  1  synchronous; zeroes count and clears err.
- a  input  1  encoder channel A, asynchronous.
- b  input  1  encoder channel B, asynchronous.
- count  output  WIDTH  position count.
- dir  output  1  direction of last valid step; 1 = up.
- step  output  1  one-cycle pulse per valid step, including steps while enable=0.
- err  output  1  sticky flag; set on an illegal transition.

Behaviour:
- Reset is asynchronous and active-high.
  - All synchroniser flops, prev_ab, count, dir, step and err go to 0.
  - FSM goes to INIT.
- Synchroniser:
  - a and b each pass through SYNC_STAGES flops; the output is ab_s = {a_s, b_s}.
  - No combinational path from a or b.
- FSM states:
  - INIT: counts SYNC_STAGES+1 cycles after reset deassertion so the pipeline fills. On the last INIT cycle, prev_ab <= ab_s; then go to RUN. No step and no err are generated in INIT.
  - RUN: each cycle, prev_ab <= ab_s and the transition prev_ab -> ab_s is decoded.
- Decode in RUN, with ab written as {a,b}:
  - Up transitions: 00->01, 01->11, 11->10, 10->00.
  - Down transitions: 00->10, 10->11, 11->01, 01->00.
  - No change: no action.
  - Both bits changed (00<->11, 01<->10): illegal. err <= 1, no step, count and dir unchanged.
- On a valid step:
  - step <= 1 for exactly one cycle.
  - dir <= 1 for up, 0 for down.
  - If enable=1, count <= count ± 1.
- Count arithmetic:
  - Modulo 2^WIDTH.
  - All-ones + 1 wraps to 0; 0 - 1 wraps to all-ones.
  - No saturation, no overflow flag.
- Latency:
  - An A/B edge that meets setup at edge N appears on count, dir and step after edge N+SYNC_STAGES.
  - That is SYNC_STAGES+1 rising edges after the input change is first sampled.
- Simultaneous events:
  - clear and step in the same cycle: clear wins. count=0 and err=0, but step and dir still reflect the step.
  - clear and illegal transition in the same cycle: err ends at 0.
  - enable=0 with a step: step and dir update, count holds.
  - On re-enable, no catch-up and no spurious count, because prev_ab was tracked continuously.
- Reset mid-operation: immediate return to the reset values, then INIT again. Input phase at reset release never produces a step.
- clear has no effect in INIT beyond holding count=0.
- Input phase rate is limited to one transition per clk cycle after synchronisation. Faster rates alias and are flagged as err where detectable.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - Adds input port idx (1 bit, asynchronous, encoder Z/index).
  - idx is synchronised with SYNC_STAGES flops, then rising-edge detected.
  - On a detected idx rising edge in RUN with enable=1, count <= 0.
  - If a step occurs in the same cycle, count <= +1 for up or all-ones for down. The index defines position 0 before the step is applied.
  - clear still overrides everything.
- Undefined: no idx port, no index logic. Port list is exactly as above.

Test Plan:
- Reset release with a=b=1 held, then hold static for 20 cycles -> count=0, step never 1, err=0.
- 8 up transitions starting at ab=00 (00,01,11,10,00,...), enable=1 -> 8 step pulses, dir=1, count=8. Each count change lands SYNC_STAGES+1 edges after its input edge.
- From count=0, apply 1 down step with WIDTH=16 -> count=0xFFFF, dir=0; then 1 up step -> count=0x0000.
- Illegal jump 00->11 -> err=1 and stays 1, count unchanged, no step. Pulse clear -> err=0, count=0.
- enable=0 during 5 up steps, then enable=1 and 2 up steps -> 7 step pulses, count=2.
- With QUAD_INDEX_EN: count at 37, idx rising edge with no step -> count=0. idx edge coincident with a down step -> count=0xFFFF.
